// File: rtl/mxint8_dot_result_checker.sv
`default_nettype none
// mxint8_dot_result_checker: in-order expected-result FIFO, result compare, counters and verdict FSM.
// Revision 1.0 - initial release
module mxint8_dot_result_checker #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int DRAIN_TO   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 exp_valid,
  output logic                 exp_ready,
  input  logic [31:0]          exp_result,
  input  logic [3:0]           exp_flags,
  input  logic                 dut_valid,
  input  logic [31:0]          dut_result,
  input  logic [3:0]           dut_flags,
  input  logic                 end_of_test,
  output logic [CNT_WIDTH-1:0] case_count,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count,
  output logic                 mismatch,
  output logic                 first_fail_valid,
  output logic [CNT_WIDTH-1:0] first_fail_case,
  output logic                 orphan_err,
  output logic                 done,
  output logic                 all_pass
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(DRAIN_TO + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;
  state_t state;

  logic [35:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] drain_timer;

  logic empty, full, push, pop, bypass, store, orphan, compare, match, fail_now, timeout;
  logic [31:0]          ref_result;
  logic [3:0]           ref_flags;
  logic [AW:0]          remaining;
  logic [CNT_WIDTH:0]   fail_sum;
  logic [CNT_WIDTH-1:0] fail_next;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign exp_ready = (state == RUN) && !full;
  assign push      = exp_valid && exp_ready;
  assign pop       = dut_valid && !empty;
  assign bypass    = dut_valid && empty && push;
  assign store     = push && !bypass;
  assign orphan    = dut_valid && empty && !push;
  assign compare   = pop || bypass;

  // An empty FIFO with a same-cycle push compares straight against the incoming entry.
  assign {ref_result, ref_flags} = pop ? mem[rd_ptr] : {exp_result, exp_flags};

  assign match = (dut_flags == ref_flags) &&
                 ((dut_result == ref_result) ||
                  (ref_flags[0] && dut_flags[0] && (dut_result[30:23] == 8'hFF) &&
                   (dut_result[22:0] != '0)));

  assign fail_now  = orphan || (compare && !match);
  assign timeout   = (state == DRAIN) && !empty && (drain_timer == TW'(DRAIN_TO - 1));
  assign remaining = count - (AW+1)'(pop);

  // Entries still queued at drain timeout are charged as missing results.
  assign fail_sum  = {1'b0, fail_count} + (CNT_WIDTH+1)'(fail_now) +
                     (timeout ? (CNT_WIDTH+1)'(remaining) : '0);
  assign fail_next = (fail_sum > {1'b0, CNT_MAX}) ? CNT_MAX : fail_sum[CNT_WIDTH-1:0];

  assign all_pass  = done && (fail_count == '0);

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= {exp_result, exp_flags};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      drain_timer      <= '0;
      case_count       <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      mismatch         <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_case  <= '0;
      orphan_err       <= 1'b0;
      done             <= 1'b0;
    end else if (clear) begin
      state            <= RUN;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      drain_timer      <= '0;
      case_count       <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      mismatch         <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_case  <= '0;
      orphan_err       <= 1'b0;
      done             <= 1'b0;
    end else begin
      mismatch <= fail_now;
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (store && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !store) count <= count - (AW+1)'(1);

      if (dut_valid && case_count != CNT_MAX) case_count <= case_count + CNT_WIDTH'(1);
      if (compare && match && pass_count != CNT_MAX) pass_count <= pass_count + CNT_WIDTH'(1);
      fail_count <= fail_next;
      if (fail_now && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_case  <= case_count;
      end
      if (orphan) orphan_err <= 1'b1;

      case (state)
        RUN: begin
          if (end_of_test) begin
            state       <= DRAIN;
            drain_timer <= '0;
          end
        end
        DRAIN: begin
          if (empty) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (timeout) begin
            state  <= DONE;
            done   <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
          end else begin
            drain_timer <= drain_timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mxint8_dot_result_checker.sv
`default_nettype none
// tb_mxint8_dot_result_checker: directed scoreboard bench for the MXINT8 result checker.
// Revision 1.0 - initial release
module tb_mxint8_dot_result_checker;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int DTO   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          exp_valid = 1'b0;
  logic          exp_ready;
  logic [31:0]   exp_result = '0;
  logic [3:0]    exp_flags = '0;
  logic          dut_valid = 1'b0;
  logic [31:0]   dut_result = '0;
  logic [3:0]    dut_flags = '0;
  logic          end_of_test = 1'b0;
  logic [CW-1:0] case_count, pass_count, fail_count, first_fail_case;
  logic          mismatch, first_fail_valid, orphan_err, done, all_pass;

  mxint8_dot_result_checker #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW), .DRAIN_TO(DTO)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_result(exp_result), .exp_flags(exp_flags),
    .dut_valid(dut_valid), .dut_result(dut_result), .dut_flags(dut_flags),
    .end_of_test(end_of_test),
    .case_count(case_count), .pass_count(pass_count), .fail_count(fail_count),
    .mismatch(mismatch), .first_fail_valid(first_fail_valid), .first_fail_case(first_fail_case),
    .orphan_err(orphan_err), .done(done), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [35:0] mq[$];
  int mcase = 0, mpass = 0, mfail = 0, mffc = 0, mstate = 0, mtimer = 0;
  bit mffv = 0, morph = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit ref_match(input logic [35:0] e, input logic [31:0] dr, input logic [3:0] df);
    bit nan_ok;
    nan_ok = e[0] && df[0] && (dr[30:23] == 8'hFF) && (dr[22:0] != 23'd0);
    return (df == e[3:0]) && ((dr == e[35:4]) || nan_ok);
  endfunction

  task automatic model_reset();
    mq.delete();
    mcase = 0; mpass = 0; mfail = 0; mffc = 0; mstate = 0; mtimer = 0;
    mffv = 0; morph = 0;
  endtask

  task automatic check_all(input bit mm);
    chk("case_count", case_count, mcase);
    chk("pass_count", pass_count, mpass);
    chk("fail_count", fail_count, mfail);
    chk("mismatch", mismatch, mm);
    chk("first_fail_valid", first_fail_valid, mffv);
    chk("first_fail_case", first_fail_case, mffc);
    chk("orphan_err", orphan_err, morph);
    chk("done", done, mstate == 2);
    chk("all_pass", all_pass, (mstate == 2) && (mfail == 0));
    chk("exp_ready", exp_ready, (mstate == 0) && (mq.size() < DEPTH));
  endtask

  // One clock cycle of stimulus; the scoreboard predicts the result of this edge.
  task automatic cyc(input logic ev, input logic [31:0] er, input logic [3:0] ef,
                     input logic dv, input logic [31:0] dr, input logic [3:0] df, input logic eot);
    bit mpush, mempty, mm, cmp;
    logic [35:0] e;
    exp_valid = ev; exp_result = er; exp_flags = ef;
    dut_valid = dv; dut_result = dr; dut_flags = df; end_of_test = eot;
    mempty = (mq.size() == 0);
    mpush  = ev && (mstate == 0) && (mq.size() < DEPTH);
    mm = 0;
    if (dv) begin
      cmp = 1;
      if (!mempty) e = mq.pop_front();
      else if (mpush) begin e = {er, ef}; mpush = 0; end
      else begin cmp = 0; morph = 1; mm = 1; end
      if (cmp) mm = !ref_match(e, dr, df);
      if (mm) begin
        mfail++;
        if (!mffv) begin mffv = 1; mffc = mcase; end
      end else mpass++;
      mcase++;
    end
    if (mpush) mq.push_back({er, ef});
    if (mstate == 0 && eot) begin mstate = 1; mtimer = 0; end
    else if (mstate == 1) begin
      if (mempty) mstate = 2;
      else if (mtimer == DTO - 1) begin mstate = 2; mfail += mq.size(); mq.delete(); end
      else mtimer++;
    end
    @(posedge clk); #1;
    exp_valid = 0; dut_valid = 0; end_of_test = 0;
    check_all(mm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    model_reset();
    check_all(0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all(0);
    rst_n = 1;

    // Three matching results returned two cycles after their expected entries
    cyc(1, 32'h3F800000, 4'h0, 0, '0, '0, 0);
    cyc(1, 32'h3F800000, 4'h0, 0, '0, '0, 0);
    cyc(1, 32'h3F800000, 4'h0, 1, 32'h3F800000, 4'h0, 0);
    cyc(0, '0, '0, 1, 32'h3F800000, 4'h0, 0);
    cyc(0, '0, '0, 1, 32'h3F800000, 4'h0, 0);
    chk("t1_pass", pass_count, 3);
    chk("t1_fail", fail_count, 0);
    chk("t1_case", case_count, 3);
    cyc(0, '0, '0, 0, '0, '0, 1);
    idle(1);
    chk("t1_done", done, 1);
    chk("t1_all_pass", all_pass, 1);

    // Second result off by one ulp
    do_clear();
    cyc(1, 32'h3F800000, 4'h0, 0, '0, '0, 0);
    cyc(1, 32'h3F800000, 4'h0, 0, '0, '0, 0);
    cyc(0, '0, '0, 1, 32'h3F800000, 4'h0, 0);
    cyc(0, '0, '0, 1, 32'h3F800001, 4'h0, 0);
    chk("t2_mismatch", mismatch, 1);
    chk("t2_fail", fail_count, 1);
    chk("t2_first_fail_case", first_fail_case, 1);
    cyc(0, '0, '0, 0, '0, '0, 1);
    idle(1);
    chk("t2_done", done, 1);
    chk("t2_all_pass", all_pass, 0);

    // NaN payloads: accepted with matching NaN flags, rejected otherwise
    do_clear();
    cyc(1, 32'h7FC00000, 4'h1, 0, '0, '0, 0);
    cyc(1, 32'h7FC00000, 4'h1, 1, 32'h7F800001, 4'h1, 0);
    chk("t3_nan_pass", pass_count, 1);
    cyc(0, '0, '0, 1, 32'h7F800001, 4'h0, 0);
    chk("t3_nan_fail", fail_count, 1);

    // Full FIFO back-pressure, pop while full, no entry lost
    do_clear();
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'h40000000 + i, 4'h0, 0, '0, '0, 0);
    chk("t4_ready_full", exp_ready, 0);
    cyc(1, 32'h40000008, 4'h0, 1, 32'h40000000, 4'h0, 0);
    chk("t4_ready_after_pop", exp_ready, 1);
    cyc(1, 32'h40000008, 4'h0, 1, 32'h40000001, 4'h0, 0);
    for (int k = 2; k <= 8; k++) cyc(0, '0, '0, 1, 32'h40000000 + k, 4'h0, 0);
    chk("t4_case", case_count, 9);
    chk("t4_pass", pass_count, 9);

    // Orphan result on empty FIFO
    do_clear();
    cyc(0, '0, '0, 1, 32'h3F800000, 4'h0, 0);
    chk("t5_orphan", orphan_err, 1);
    chk("t5_fail", fail_count, 1);
    chk("t5_first_fail_case", first_fail_case, 0);

    // Drain timeout with two entries left
    do_clear();
    cyc(1, 32'h3F800000, 4'h0, 0, '0, '0, 0);
    cyc(1, 32'h3F800000, 4'h0, 0, '0, '0, 0);
    cyc(0, '0, '0, 0, '0, '0, 1);
    idle(DTO - 1);
    chk("t6_not_done", done, 0);
    idle(1);
    chk("t6_done", done, 1);
    chk("t6_fail_missing", fail_count, 2);

    // Asynchronous reset in the middle of DRAIN
    do_clear();
    cyc(1, 32'h3F800000, 4'h0, 0, '0, '0, 0);
    cyc(1, 32'h3F800000, 4'h0, 1, 32'h3F800000, 4'h0, 0);
    cyc(0, '0, '0, 0, '0, '0, 1);
    idle(3);
    #2 rst_n = 0;
    #1;
    chk("t7_case", case_count, 0);
    chk("t7_pass", pass_count, 0);
    chk("t7_ready", exp_ready, 1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    check_all(0);
    cyc(1, 32'h3F800000, 4'h0, 1, 32'h3F800000, 4'h0, 0);
    chk("t7_bypass_pass", pass_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
